out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Wormhole output-port arbiter for the NoC switch. It shares one switch output port (including the IP-facing port) among `IN_NUM` input buffers. It locks the port to one input from the head flit through the tail flit of a packet, and places a one-flit output register in front of the downstream link. Round-robin fairness between packets, a lock watchdog and a sent-packet counter sit beside the datapath.

## Interface
Parameters:
- `DATA_SIZE`, 32: payload bits per flit.
- `ADDR_SIZE`, 4: destination address bits per flit.
- `IN_NUM`, 5: number of requesting inputs (`PORTS_NUM` + 1 for IP).
- `TIMEOUT`, 64: idle-owner cycles before forced release; 0 disables the watchdog. Must be less than 65536.
- Derived: `FLIT = DATA_SIZE + ADDR_SIZE + 1`. Flit layout is {eop, addr, data}, with bit `FLIT-1` = end-of-packet.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `a_rst`  in  1  reset, asynchronous, active-low.
- `data_i`  in  IN_NUM*FLIT  input i flit at `[i*FLIT +: FLIT]`.
- `wr_ready_in`  in  IN_NUM  input i presents a valid flit.
- `r_ready_out`  out  IN_NUM  pop strobe: input i flit is taken this cycle (at most one bit high).
- `data_o`  out  FLIT  output register contents.
- `wr_ready_out`  out  1  output register holds a valid flit.
- `r_ready_in`  in  1  downstream accepts `data_o` this cycle.
- `grant_o`  out  IN_NUM  one-hot current owner; all-zero when idle.
- `sent_packs`  out  32  count of tail flits popped; wraps modulo 2^32.
- `err_timeout`  out  1  sticky watchdog-release flag; cleared only by reset.

## Operation
- **State.** FSM states are IDLE and LOCKED. Registers: `owner` (index), `rr_ptr` (index), `wd_cnt` (16 bits), and the output register with its valid bit.
- **IDLE.** If any `wr_ready_in` bit is high, select the first set index scanning `rr_ptr`, `rr_ptr+1`, …, wrapping modulo `IN_NUM`. Register it as `owner` and go to LOCKED. No pop occurs in an IDLE cycle.
- **LOCKED pop condition.** `r_ready_out[owner] = wr_ready_in[owner] & (!wr_ready_out | r_ready_in)`. This is combinational.
- **LOCKED pop effects.** On a pop, load `data_i[owner]` into the output register, set valid, and clear `wd_cnt`.
- **Tail pop.** If the popped flit has eop = 1:
  - go to IDLE;
  - set `rr_ptr = (owner+1) mod IN_NUM`;
  - increment `sent_packs`.
  - A single-flit packet carries eop = 1 in its only flit.
- **Drain.** When `wr_ready_out & r_ready_in` and there is no pop in the same cycle, clear valid. A drain and a pop in the same cycle keep valid = 1, with the new flit replacing the old.
- **Watchdog counting.** In LOCKED, while `wr_ready_in[owner]` = 0, increment `wd_cnt`. Backpressure (owner has data but `r_ready_in` = 0) neither counts nor clears it.
- **Watchdog release.** When `wd_cnt` reaches `TIMEOUT` (and `TIMEOUT` ≠ 0):
  - go to IDLE;
  - set `rr_ptr = owner+1`;
  - set `err_timeout` = 1;
  - leave `sent_packs` unchanged;
  - keep any flit already in the output register and drain it normally.
- **Grant.** `grant_o` is the one-hot decode of `owner` in LOCKED, and zero in IDLE.
- **Non-owners.** Requests from non-owners are ignored while LOCKED. Their `r_ready_out` stays 0.

## Timing
- **Reset.** While `a_rst` = 0, immediately:
  - `data_o` = 0, `wr_ready_out` = 0, `grant_o` = 0, `sent_packs` = 0, `err_timeout` = 0;
  - `r_ready_out` = 0;
  - state IDLE, `rr_ptr` = 0, `wd_cnt` = 0.
- **Reset mid-packet.** The partial packet is discarded. After release, arbitration restarts from input 0.
- **Request to grant.** A request seen in IDLE at edge t gives `grant_o` valid after t. The first pop is possible in cycle t+1, and `data_o`/`wr_ready_out` are valid after edge t+1.
- **Throughput.** Within a packet, one flit per cycle under continuous `r_ready_in` = 1.
- **Packet gap.** Exactly one idle arbitration cycle between a tail pop and the next head pop.
- **Pop to output.** Latency is 1 cycle.
- **Combinational path.** `r_ready_in` → `r_ready_out` is combinational and must not loop back to `wr_ready_in` within one cycle.

## Test plan
- **Reset.** Hold `a_rst` = 0 with random inputs. Required: all outputs 0. Release `a_rst` and hold `wr_ready_in` = 0 for 10 cycles. Required: still all zero.
- **Single packet.** Input 2 sends 3 flits (eop only on the third), `r_ready_in` = 1.
  - `grant_o` = 5'b00100 one cycle after the request.
  - `data_o` shows the 3 flits on consecutive cycles.
  - `sent_packs` = 1, then `grant_o` = 0.
- **Round robin.** Inputs 0, 1 and 3 continuously send 1-flit packets.
  - Grant order 0, 1, 3, 0, 1, 3.
  - One idle cycle between grants.
  - `sent_packs` = 6 after 6 packets.
- **Backpressure.** With a 4-flit packet from input 4, hold `r_ready_in` = 0 for 5 cycles after flit 2.
  - `data_o` holds flit 2 and `r_ready_out` = 0.
  - All 4 flits arrive in order.
  - `err_timeout` stays 0 with `TIMEOUT` = 4.
- **Watchdog.** With `TIMEOUT` = 8, input 1 sends a head flit (eop = 0), then drops `wr_ready_in`.
  - Release occurs 8 cycles later with `err_timeout` = 1.
  - Pending input 3 is granted next.
  - `sent_packs` is unchanged.
- **Mid-packet reset and wrap.** Assert reset after flit 2 of 5. Required: all outputs 0 and the next grant goes to input 0. Separately, preload `sent_packs` near 2^32−1. Required: it wraps to 0 after one more tail flit.

Source files
------------

// File: rtl/out_port_arbiter.sv
// Wormhole output-port arbiter: locks one switch output to a single input from head to tail,
// with round-robin packet fairness, an idle-owner watchdog and a one-flit output register.
module out_port_arbiter #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned IN_NUM    = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                                        clk,
  input  logic                                        a_rst,
  input  logic [IN_NUM*(DATA_SIZE+ADDR_SIZE+1)-1:0]   data_i,
  input  logic [IN_NUM-1:0]                           wr_ready_in,
  output logic [IN_NUM-1:0]                           r_ready_out,
  output logic [DATA_SIZE+ADDR_SIZE:0]                data_o,
  output logic                                        wr_ready_out,
  input  logic                                        r_ready_in,
  output logic [IN_NUM-1:0]                           grant_o,
  output logic [31:0]                                 sent_packs,
  output logic                                        err_timeout
);

  localparam int unsigned FLIT = DATA_SIZE + ADDR_SIZE + 1;
  localparam int unsigned IW   = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam int unsigned IW1  = IW + 1;
  localparam int unsigned WDW  = 16;
  localparam logic            WD_EN   = (TIMEOUT != 0);
  localparam logic [WDW-1:0]  WD_LAST = (TIMEOUT == 0) ? WDW'(0) : WDW'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr_ptr;
  logic [WDW-1:0]     r_wd_cnt;
  logic [FLIT-1:0]    r_data;
  logic               r_valid;
  logic [IN_NUM-1:0]  r_grant;
  logic [31:0]        r_sent_packs;
  logic               r_err;

  logic [IW-1:0]      w_sel;
  logic               w_found;
  logic [IW1-1:0]     w_idx;
  logic [FLIT-1:0]    w_flit;
  logic               w_req_own;
  logic               w_pop;
  logic               w_wd_fire;
  logic [IW-1:0]      w_next_own;
  logic [IN_NUM-1:0]  w_sel_oh;
  logic [IN_NUM-1:0]  w_own_oh;

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo IN_NUM.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < IN_NUM; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IW1'(k);
      if (w_idx >= IW1'(IN_NUM)) w_idx = w_idx - IW1'(IN_NUM);
      if (!w_found && wr_ready_in[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IW-1:0];
      end
    end
  end

  // Owner-side mux of flit and request.
  always_comb begin
    w_flit    = '0;
    w_req_own = 1'b0;
    for (int k = 0; k < IN_NUM; k++) begin
      if (r_owner == IW'(k)) begin
        w_flit    = data_i[k*FLIT +: FLIT];
        w_req_own = wr_ready_in[k];
      end
    end
  end

  assign w_sel_oh   = IN_NUM'(1) << w_sel;
  assign w_own_oh   = IN_NUM'(1) << r_owner;
  assign w_next_own = (r_owner == IW'(IN_NUM - 1)) ? '0 : r_owner + IW'(1);
  assign w_pop      = (r_state == ST_LOCKED) && w_req_own && (!r_valid || r_ready_in);
  assign w_wd_fire  = WD_EN && (r_state == ST_LOCKED) && !w_req_own && (r_wd_cnt == WD_LAST);

  assign r_ready_out  = w_pop ? w_own_oh : '0;
  assign data_o       = r_data;
  assign wr_ready_out = r_valid;
  assign grant_o      = r_grant;
  assign sent_packs   = r_sent_packs;
  assign err_timeout  = r_err;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_wd_cnt     <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_grant      <= '0;
      r_sent_packs <= '0;
      r_err        <= 1'b0;
    end else begin
      // A pop in the same cycle as a drain simply replaces the held flit.
      if (w_pop) begin
        r_data  <= w_flit;
        r_valid <= 1'b1;
      end else if (r_valid && r_ready_in) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_wd_cnt <= '0;
          if (w_found) begin
            r_owner <= w_sel;
            r_grant <= w_sel_oh;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_pop) begin
            r_wd_cnt <= '0;
            if (w_flit[FLIT-1]) begin
              r_state      <= ST_IDLE;
              r_grant      <= '0;
              r_rr_ptr     <= w_next_own;
              r_sent_packs <= r_sent_packs + 32'd1;
            end
          end else if (w_wd_fire) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_own;
            r_wd_cnt <= '0;
            r_err    <= 1'b1;
          end else if (!w_req_own) begin
            // Backpressure with data waiting does not count as an idle owner.
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed self-checking bench for out_port_arbiter; dut_a uses TIMEOUT=4, dut_b uses TIMEOUT=8.
module tb_out_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned N  = 5;
  localparam int unsigned F  = DW + AW + 1;

  logic          clk = 1'b0;
  logic          a_rst;
  logic [N*F-1:0] data_i;
  logic [N-1:0]  wr_ready_in;
  logic          r_ready_in;

  logic [N-1:0]  rro_a, g_a, rro_b, g_b;
  logic [F-1:0]  do_a, do_b;
  logic          wro_a, wro_b, et_a, et_b;
  logic [31:0]   sp_a, sp_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  out_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .IN_NUM(N), .TIMEOUT(4)) dut_a (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
    .r_ready_out(rro_a), .data_o(do_a), .wr_ready_out(wro_a), .r_ready_in(r_ready_in),
    .grant_o(g_a), .sent_packs(sp_a), .err_timeout(et_a)
  );

  out_port_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .IN_NUM(N), .TIMEOUT(8)) dut_b (
    .clk(clk), .a_rst(a_rst), .data_i(data_i), .wr_ready_in(wr_ready_in),
    .r_ready_out(rro_b), .data_o(do_b), .wr_ready_out(wro_b), .r_ready_in(r_ready_in),
    .grant_o(g_b), .sent_packs(sp_b), .err_timeout(et_b)
  );

  function automatic logic [F-1:0] mk(input logic eop, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {eop, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flit(input int i, input logic [F-1:0] f);
    data_i[i*F +: F] = f;
  endtask

  task automatic do_reset();
    a_rst       = 1'b0;
    wr_ready_in = '0;
    data_i      = '0;
    r_ready_in  = 1'b1;
    #3;
    a_rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [N+F+1+N+32+1-1:0] obs;
    a_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < N; k++) data_i[k*F +: F] = F'({$urandom, $urandom});
      wr_ready_in = N'($urandom);
      r_ready_in  = 1'($urandom);
      #1;
      obs = {rro_a, do_a, wro_a, g_a, sp_a, et_a};
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_hold_a got=%h exp=0", obs); end
      total++;
      if ({rro_b, do_b, wro_b, g_b, sp_b, et_b} !== '0) begin
        bad++; $display("FAIL reset_hold_b got=%h exp=0", {rro_b, do_b, wro_b, g_b, sp_b, et_b});
      end
      tick();
    end
    wr_ready_in = '0;
    r_ready_in  = 1'b1;
    #2;
    a_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      obs = {rro_a, do_a, wro_a, g_a, sp_a, et_a};
      total++;
      if (obs !== '0) begin bad++; $display("FAIL reset_idle c=%0d got=%h exp=0", c, obs); end
    end
  endtask

  task automatic test_single_packet();
    logic [F-1:0] f [3];
    f[0] = mk(1'b0, 4'h2, 32'h1111_0000);
    f[1] = mk(1'b0, 4'h2, 32'h1111_0001);
    f[2] = mk(1'b1, 4'h2, 32'h1111_0002);
    do_reset();
    set_flit(2, f[0]);
    wr_ready_in = 5'b00100;
    tick();
    total++;
    if (g_a !== 5'b00100) begin bad++; $display("FAIL single_grant got=%b exp=00100", g_a); end
    total++;
    if (wro_a !== 1'b0) begin bad++; $display("FAIL single_no_pop_idle got=%b exp=0", wro_a); end
    total++;
    if (rro_a !== 5'b00100) begin bad++; $display("FAIL single_rro got=%b exp=00100", rro_a); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (do_a !== f[k] || wro_a !== 1'b1) begin
        bad++; $display("FAIL single_data k=%0d got=%h/%b exp=%h/1", k, do_a, wro_a, f[k]);
      end
      if (k < 2) set_flit(2, f[k+1]);
    end
    wr_ready_in = '0;
    total++;
    if (sp_a !== 32'd1) begin bad++; $display("FAIL single_sent got=%0d exp=1", sp_a); end
    total++;
    if (g_a !== 5'b00000) begin bad++; $display("FAIL single_release got=%b exp=00000", g_a); end
  endtask

  task automatic test_round_robin();
    int           order [3];
    logic [F-1:0] fl;
    order[0] = 0; order[1] = 1; order[2] = 3;
    do_reset();
    for (int k = 0; k < 3; k++) set_flit(order[k], mk(1'b1, AW'(order[k]), 32'hC0DE_0000 + 32'(order[k])));
    wr_ready_in = 5'b01011;
    for (int p = 0; p < 6; p++) begin
      tick();
      total++;
      if (g_a !== N'(1) << order[p % 3]) begin
        bad++; $display("FAIL rr_grant p=%0d got=%b exp_idx=%0d", p, g_a, order[p % 3]);
      end
      tick();
      fl = mk(1'b1, AW'(order[p % 3]), 32'hC0DE_0000 + 32'(order[p % 3]));
      total++;
      if (g_a !== '0 || do_a !== fl) begin
        bad++; $display("FAIL rr_pop p=%0d got=%b/%h exp=00000/%h", p, g_a, do_a, fl);
      end
    end
    wr_ready_in = '0;
    total++;
    if (sp_a !== 32'd6) begin bad++; $display("FAIL rr_sent got=%0d exp=6", sp_a); end
  endtask

  task automatic test_backpressure();
    logic [F-1:0] f [4];
    for (int k = 0; k < 4; k++) f[k] = mk(k == 3, 4'h4, 32'hB000_0000 + 32'(k));
    do_reset();
    set_flit(4, f[0]);
    wr_ready_in = 5'b10000;
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (do_a !== f[k]) begin bad++; $display("FAIL bp_lead k=%0d got=%h exp=%h", k, do_a, f[k]); end
      set_flit(4, f[k+1]);
    end
    r_ready_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (rro_a !== '0) begin bad++; $display("FAIL bp_rro c=%0d got=%b exp=00000", c, rro_a); end
      tick();
      total++;
      if (do_a !== f[1] || wro_a !== 1'b1 || et_a !== 1'b0) begin
        bad++; $display("FAIL bp_hold c=%0d got=%h/%b/%b exp=%h/1/0", c, do_a, wro_a, et_a, f[1]);
      end
    end
    r_ready_in = 1'b1;
    #1;
    total++;
    if (rro_a !== 5'b10000) begin bad++; $display("FAIL bp_resume got=%b exp=10000", rro_a); end
    for (int k = 2; k < 4; k++) begin
      tick();
      total++;
      if (do_a !== f[k]) begin bad++; $display("FAIL bp_tail k=%0d got=%h exp=%h", k, do_a, f[k]); end
      if (k < 3) set_flit(4, f[k+1]);
    end
    wr_ready_in = '0;
    total++;
    if (sp_a !== 32'd1 || et_a !== 1'b0 || g_a !== '0) begin
      bad++; $display("FAIL bp_end got=%0d/%b/%b exp=1/0/00000", sp_a, et_a, g_a);
    end
  endtask

  task automatic test_watchdog();
    logic [F-1:0] head, tail3;
    head  = mk(1'b0, 4'h1, 32'hDEAD_0001);
    tail3 = mk(1'b1, 4'h3, 32'hBEEF_0003);
    do_reset();
    set_flit(1, head);
    wr_ready_in = 5'b00010;
    tick();
    tick();
    total++;
    if (do_b !== head) begin bad++; $display("FAIL wd_head got=%h exp=%h", do_b, head); end
    set_flit(3, tail3);
    wr_ready_in = 5'b01000;
    for (int c = 1; c < 8; c++) begin
      #1;
      total++;
      if (rro_b !== '0) begin bad++; $display("FAIL wd_nonowner c=%0d got=%b exp=00000", c, rro_b); end
      tick();
      total++;
      if (g_b !== 5'b00010 || et_b !== 1'b0) begin
        bad++; $display("FAIL wd_hold c=%0d got=%b/%b exp=00010/0", c, g_b, et_b);
      end
    end
    tick();
    total++;
    if (g_b !== '0 || et_b !== 1'b1 || sp_b !== 32'd0) begin
      bad++; $display("FAIL wd_fire got=%b/%b/%0d exp=00000/1/0", g_b, et_b, sp_b);
    end
    tick();
    total++;
    if (g_b !== 5'b01000) begin bad++; $display("FAIL wd_next_grant got=%b exp=01000", g_b); end
    tick();
    wr_ready_in = '0;
    total++;
    if (do_b !== tail3 || sp_b !== 32'd1 || et_b !== 1'b1) begin
      bad++; $display("FAIL wd_after got=%h/%0d/%b exp=%h/1/1", do_b, sp_b, et_b, tail3);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    logic [F-1:0] f [3];
    logic [F-1:0] w;
    for (int k = 0; k < 3; k++) f[k] = mk(1'b0, 4'h1, 32'h5000_0000 + 32'(k));
    w = mk(1'b1, 4'h0, 32'h0000_0A0A);
    do_reset();
    set_flit(0, w);
    wr_ready_in = 5'b00001;
    tick();
    tick();
    set_flit(1, f[0]);
    wr_ready_in = 5'b00010;
    tick();
    total++;
    if (g_a !== 5'b00010) begin bad++; $display("FAIL mid_grant got=%b exp=00010", g_a); end
    for (int k = 0; k < 2; k++) begin
      tick();
      set_flit(1, f[k+1]);
    end
    total++;
    if (do_a !== f[1]) begin bad++; $display("FAIL mid_flit2 got=%h exp=%h", do_a, f[1]); end
    a_rst = 1'b0;
    #1;
    total++;
    if ({rro_a, do_a, wro_a, g_a, sp_a, et_a} !== '0) begin
      bad++; $display("FAIL mid_reset got=%h exp=0", {rro_a, do_a, wro_a, g_a, sp_a, et_a});
    end
    wr_ready_in = 5'b00011;
    tick();
    a_rst = 1'b1;
    tick();
    total++;
    if (g_a !== 5'b00001) begin bad++; $display("FAIL mid_restart got=%b exp=00001", g_a); end
    force dut_a.r_sent_packs = 32'hFFFF_FFFF;
    #1;
    release dut_a.r_sent_packs;
    tick();
    wr_ready_in = '0;
    total++;
    if (sp_a !== 32'd0 || do_a !== w) begin
      bad++; $display("FAIL wrap got=%h/%h exp=00000000/%h", sp_a, do_a, w);
    end
  endtask

  initial begin
    a_rst       = 1'b0;
    wr_ready_in = '0;
    data_i      = '0;
    r_ready_in  = 1'b1;
    #2;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
